// File: rtl/sq_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sq_drain_ctrl_pkg
//  Description : Shared LSU definitions for the store-queue drain controller.
//                Holds the store geometry, the drain FSM state encoding and
//                the store request record that is used both for the SQ head
//                latch and for the memory write request.
//  Revision    : 1.0  - initial release
// ============================================================================
package sq_drain_ctrl_pkg;

   // Store geometry. store_req_t is sized from these values, so any
   // sq_drain_ctrl instance must use matching parameter values.
   localparam int LSU_ROB_IDX_WIDTH = 6;
   localparam int LSU_ADDR_WIDTH    = 32;
   localparam int LSU_DATA_WIDTH    = 32;
   localparam int LSU_BE_WIDTH      = LSU_DATA_WIDTH / 8;
   localparam int LSU_SQ_DEPTH      = 16;
   localparam int LSU_COMMIT_WIDTH  = 2;

   // Width of the committed-but-undrained store counter (0..SQ_DEPTH).
   localparam int CNT_W = $clog2(LSU_SQ_DEPTH + 1);

   // Drain FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } sq_drain_state_e;

   // One store as presented at the SQ head and as sent to memory.
   typedef struct packed {
      logic [LSU_ADDR_WIDTH-1:0]    addr;
      logic [LSU_DATA_WIDTH-1:0]    data;
      logic [LSU_BE_WIDTH-1:0]      be;
      logic [LSU_ROB_IDX_WIDTH-1:0] rob_tag;
   } store_req_t;

endpackage : sq_drain_ctrl_pkg
`default_nettype wire

// File: rtl/sq_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sq_drain_ctrl
//  Description : Retires committed stores from the store-queue head into the
//                data-memory write port. Keeps a count of stores the ROB has
//                committed but that have not yet been written, runs a
//                single-outstanding request/response handshake with memory,
//                and pops the SQ head once memory completes the write.
//
//  Ports
//    clk_i               clock
//    rst_i               synchronous active-high reset
//    flush_i             pipeline flush (only legal while drain_busy_o = 0)
//    commit_store_cnt_i  stores committed by the ROB this cycle
//    sq_head_*_i         SQ head entry (valid, rob tag, addr, data, be)
//    sq_pop_valid_o      one-cycle pop of the SQ head
//    mem_req_*           write request channel (valid/ready + payload)
//    mem_resp_valid_i    write completion
//    mem_resp_err_i      completion carries a bus error
//    store_err_o         one-cycle pulse on an errored completion
//    pending_cnt_o       committed-but-undrained store count
//    drain_busy_o        pending work or a store in flight
//
//  Revision    : 1.0  - initial release
// ============================================================================
module sq_drain_ctrl
   import sq_drain_ctrl_pkg::*;
#(
   parameter int ROB_IDX_WIDTH = LSU_ROB_IDX_WIDTH,
   parameter int ADDR_WIDTH    = LSU_ADDR_WIDTH,
   parameter int DATA_WIDTH    = LSU_DATA_WIDTH,
   parameter int SQ_DEPTH      = LSU_SQ_DEPTH,
   parameter int COMMIT_WIDTH  = LSU_COMMIT_WIDTH
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0]  commit_store_cnt_i,
   input  logic                               sq_head_valid_i,
   input  logic [ROB_IDX_WIDTH-1:0]           sq_head_rob_tag_i,
   input  logic [ADDR_WIDTH-1:0]              sq_head_addr_i,
   input  logic [DATA_WIDTH-1:0]              sq_head_data_i,
   input  logic [DATA_WIDTH/8-1:0]            sq_head_be_i,
   output logic                               sq_pop_valid_o,
   output logic                               mem_req_valid_o,
   input  logic                               mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
   output logic [DATA_WIDTH-1:0]              mem_req_data_o,
   output logic [DATA_WIDTH/8-1:0]            mem_req_be_o,
   output logic [ROB_IDX_WIDTH-1:0]           mem_req_rob_tag_o,
   input  logic                               mem_resp_valid_i,
   input  logic                               mem_resp_err_i,
   output logic                               store_err_o,
   output logic [$clog2(SQ_DEPTH+1)-1:0]      pending_cnt_o,
   output logic                               drain_busy_o
);

   localparam int PCNT_W = $clog2(SQ_DEPTH + 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   sq_drain_state_e       state_q;
   store_req_t            req_q;      // latched SQ head, drives the request
   logic [PCNT_W-1:0]     pending_q;
   logic [PCNT_W-1:0]     pending_d;
   logic [PCNT_W:0]       pending_sum; // one extra bit to expose overflow
   logic                  pop;
   logic                  head_take;
   store_req_t            head_req;

   // The SQ entry leaves only when memory reports completion, so the head
   // stays in the queue for the whole time its write is in flight.
   assign pop       = (state_q == RESP) && mem_resp_valid_i;

   // Qualification uses the registered count: a commit seen this cycle does
   // not start a drain until the following cycle.
   assign head_take = (state_q == IDLE) && (pending_q != '0) && sq_head_valid_i;

   assign head_req.addr    = sq_head_addr_i;
   assign head_req.data    = sq_head_data_i;
   assign head_req.be      = sq_head_be_i;
   assign head_req.rob_tag = sq_head_rob_tag_i;

   // Commit and pop in the same cycle are both applied.
   assign pending_sum = {1'b0, pending_q}
                      + (PCNT_W+1)'(commit_store_cnt_i)
                      - (PCNT_W+1)'(pop);
   assign pending_d   = pending_sum[PCNT_W-1:0];

   // ------------------------------------------------------------------------
   // FSM, pending counter and request payload register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
         req_q     <= '0;
      end else if (flush_i) begin
         // Only reachable while idle with nothing pending, so nothing
         // committed is ever lost here.
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            IDLE: begin
               if (head_take) begin
                  req_q   <= head_req;
                  state_q <= REQ;
               end
            end
            REQ: begin
               // Payload is held in req_q until the request is accepted.
               if (mem_req_ready_i) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               // Errored writes are popped as well; the error is only
               // reported, never retried.
               if (mem_resp_valid_i) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign mem_req_valid_o   = (state_q == REQ);
   assign mem_req_addr_o    = req_q.addr;
   assign mem_req_data_o    = req_q.data;
   assign mem_req_be_o      = req_q.be;
   assign mem_req_rob_tag_o = req_q.rob_tag;

   assign sq_pop_valid_o    = pop;
   assign store_err_o       = pop && mem_resp_err_i;
   assign pending_cnt_o     = pending_q;
   assign drain_busy_o      = (pending_q != '0) || (state_q != IDLE);

   // ------------------------------------------------------------------------
   // Protocol checks
   // ------------------------------------------------------------------------
`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         // Counter never exceeds the SQ depth and never wraps below zero.
         a_no_overflow  : assert (flush_i || (pending_sum <= (PCNT_W+1)'(SQ_DEPTH)));
         a_no_underflow : assert (!(pop && (pending_q == '0)));
         // Flushing would discard committed stores while busy.
         a_flush_idle   : assert (!(flush_i && drain_busy_o));
         // Completions are only expected while waiting for one.
         a_resp_in_resp : assert (!(mem_resp_valid_i && (state_q != RESP)));
         // A committed store must have a matching SQ entry.
         a_head_present : assert (!((pending_q != '0) && !sq_head_valid_i));
      end
   end
`endif

endmodule : sq_drain_ctrl
`default_nettype wire

// File: tb/tb_sq_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sq_drain_ctrl
//  Description : Self-checking bench for sq_drain_ctrl. A small SQ model
//                feeds the head, a memory model answers one cycle after
//                acceptance, and a scoreboard of expected writes is compared
//                against every accepted request and every pop.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_sq_drain_ctrl;

   localparam int ROB_W = 6;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int CMTW  = 2;
   localparam int PW    = $clog2(DEPTH + 1);
   localparam int CW    = $clog2(CMTW + 1);

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              flush_i = 1'b0;
   logic [CW-1:0]     commit_store_cnt_i = '0;
   logic              sq_head_valid_i = 1'b0;
   logic [ROB_W-1:0]  sq_head_rob_tag_i = '0;
   logic [AW-1:0]     sq_head_addr_i = '0;
   logic [DW-1:0]     sq_head_data_i = '0;
   logic [BW-1:0]     sq_head_be_i = '0;
   logic              sq_pop_valid_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready_i = 1'b1;
   logic [AW-1:0]     mem_req_addr_o;
   logic [DW-1:0]     mem_req_data_o;
   logic [BW-1:0]     mem_req_be_o;
   logic [ROB_W-1:0]  mem_req_rob_tag_o;
   logic              mem_resp_valid_i = 1'b0;
   logic              mem_resp_err_i = 1'b0;
   logic              store_err_o;
   logic [PW-1:0]     pending_cnt_o;
   logic              drain_busy_o;

   always #5 clk = ~clk;

   sq_drain_ctrl #(
      .ROB_IDX_WIDTH (ROB_W),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .SQ_DEPTH      (DEPTH),
      .COMMIT_WIDTH  (CMTW)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .flush_i            (flush_i),
      .commit_store_cnt_i (commit_store_cnt_i),
      .sq_head_valid_i    (sq_head_valid_i),
      .sq_head_rob_tag_i  (sq_head_rob_tag_i),
      .sq_head_addr_i     (sq_head_addr_i),
      .sq_head_data_i     (sq_head_data_i),
      .sq_head_be_i       (sq_head_be_i),
      .sq_pop_valid_o     (sq_pop_valid_o),
      .mem_req_valid_o    (mem_req_valid_o),
      .mem_req_ready_i    (mem_req_ready_i),
      .mem_req_addr_o     (mem_req_addr_o),
      .mem_req_data_o     (mem_req_data_o),
      .mem_req_be_o       (mem_req_be_o),
      .mem_req_rob_tag_o  (mem_req_rob_tag_o),
      .mem_resp_valid_i   (mem_resp_valid_i),
      .mem_resp_err_i     (mem_resp_err_i),
      .store_err_o        (store_err_o),
      .pending_cnt_o      (pending_cnt_o),
      .drain_busy_o       (drain_busy_o)
   );

   typedef struct {
      logic [AW-1:0]    addr;
      logic [DW-1:0]    data;
      logic [BW-1:0]    be;
      logic [ROB_W-1:0] tag;
      bit               err;
   } ent_t;

   ent_t sq_q[$];      // store queue model (head = front)
   ent_t exp_q[$];     // expected memory writes, in SQ order
   bit   infl_err[$];  // error flag of the accepted, not yet popped write

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   int req_cnt = 0;
   int err_pulses = 0;
   int max_pend = 0;
   logic [ROB_W-1:0] tag_ctr = '0;

   // ------------------------------------------------------------------------
   // SQ model, memory model and scoreboard
   // ------------------------------------------------------------------------
   initial begin : monitor
      ent_t e;
      bit   acc, popd, acc_err, exp_err;
      forever begin
         @(negedge clk);
         acc = 1'b0; popd = 1'b0; acc_err = 1'b0;
         if (!rst_i) begin
            if (int'(pending_cnt_o) > max_pend) max_pend = int'(pending_cnt_o);
            if (mem_req_valid_o && mem_req_ready_i) begin
               acc = 1'b1;
               req_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL req_unexpected: got addr %h, required no request", mem_req_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  acc_err = e.err;
                  infl_err.push_back(e.err);
                  if ({mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_rob_tag_o}
                      !== {e.addr, e.data, e.be, e.tag}) begin
                     errors++;
                     $display("FAIL req_payload: got %h/%h/%h/%h required %h/%h/%h/%h",
                              mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_rob_tag_o,
                              e.addr, e.data, e.be, e.tag);
                  end
               end
            end
            if (sq_pop_valid_o) begin
               popd = 1'b1;
               pop_cnt++;
               checks++;
               if (infl_err.size() == 0) begin
                  errors++;
                  $display("FAIL pop_unexpected: got pop, required none");
               end else begin
                  exp_err = infl_err.pop_front();
                  if (store_err_o !== exp_err) begin
                     errors++;
                     $display("FAIL store_err: got %b required %b", store_err_o, exp_err);
                  end
               end
            end
            if (store_err_o) err_pulses++;
         end
         @(posedge clk);
         #2;
         if (popd && sq_q.size() != 0) void'(sq_q.pop_front());
         if (sq_q.size() != 0) begin
            sq_head_valid_i   = 1'b1;
            sq_head_addr_i    = sq_q[0].addr;
            sq_head_data_i    = sq_q[0].data;
            sq_head_be_i      = sq_q[0].be;
            sq_head_rob_tag_i = sq_q[0].tag;
         end else begin
            sq_head_valid_i   = 1'b0;
         end
         mem_resp_valid_i = acc;
         mem_resp_err_i   = acc ? acc_err : 1'b0;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Helpers (stimulus only)
   // ------------------------------------------------------------------------
   task automatic alloc(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] b, input bit err);
      ent_t e;
      e.addr = a; e.data = d; e.be = b; e.tag = tag_ctr; e.err = err;
      tag_ctr = tag_ctr + 1'b1;
      sq_q.push_back(e);
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!drain_busy_o && exp_q.size() == 0 && infl_err.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: busy=%b outstanding=%0d, required idle", drain_busy_o, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", mem_req_valid_o); end
      checks++;
      if (pending_cnt_o !== '0) begin errors++; $display("FAIL rst_pending: got %0d required 0", pending_cnt_o); end
      checks++;
      if ({drain_busy_o, sq_pop_valid_o, store_err_o} !== 3'b000) begin
         errors++; $display("FAIL rst_flags: got %b required 000", {drain_busy_o, sq_pop_valid_o, store_err_o});
      end
      checks++;
      if ({mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_rob_tag_o} !== '0) begin
         errors++; $display("FAIL rst_payload: got %h required 0", {mem_req_addr_o, mem_req_data_o});
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_single();
      int n = 0;
      int r0 = req_cnt;
      @(posedge clk); #1;
      alloc(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      checks++;
      if (pending_cnt_o !== 5'd1) begin errors++; $display("FAIL single_pending_up: got %0d required 1", pending_cnt_o); end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (sq_pop_valid_o) begin n = i; break; end
      end
      checks++;
      if (n != 3) begin errors++; $display("FAIL single_pop_latency: got %0d required 3", n); end
      wait_idle();
      checks++;
      if (req_cnt - r0 != 1) begin errors++; $display("FAIL single_req_count: got %0d required 1", req_cnt - r0); end
      checks++;
      if (pending_cnt_o !== '0) begin errors++; $display("FAIL single_pending_down: got %0d required 0", pending_cnt_o); end
   endtask

   task automatic test_backpressure();
      bit seen = 1'b0;
      mem_req_ready_i = 1'b0;
      alloc(32'h200, 32'hCAFEF00D, 4'h3, 1'b0);
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req_valid_o) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL bp_no_request: got valid=0 required 1"); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({mem_req_valid_o, sq_pop_valid_o, drain_busy_o} !== 3'b101) begin
            errors++; $display("FAIL bp_handshake: cycle %0d got valid/pop/busy %b required 101", i,
                               {mem_req_valid_o, sq_pop_valid_o, drain_busy_o});
         end
         checks++;
         if ({mem_req_addr_o, mem_req_data_o, mem_req_be_o} !== {32'h200, 32'hCAFEF00D, 4'h3}) begin
            errors++; $display("FAIL bp_payload: cycle %0d got %h/%h/%h required 200/cafef00d/3", i,
                               mem_req_addr_o, mem_req_data_o, mem_req_be_o);
         end
      end
      @(posedge clk); #1;
      mem_req_ready_i = 1'b1;
      wait_idle();
   endtask

   task automatic test_burst();
      int p0 = pop_cnt;
      for (int i = 0; i < 8; i++) alloc(32'h1000 + 32'(i * 4), 32'hA5A50000 + 32'(i), 4'hF, 1'b0);
      max_pend = 0;
      for (int i = 0; i < 4; i++) begin
         commit_store_cnt_i = 2'd2;
         @(posedge clk); #1;
      end
      commit_store_cnt_i = 2'd0;
      wait_idle();
      checks++;
      if (pop_cnt - p0 != 8) begin errors++; $display("FAIL burst_pops: got %0d required 8", pop_cnt - p0); end
      checks++;
      if (max_pend != 7) begin errors++; $display("FAIL burst_peak: got %0d required 7", max_pend); end
      checks++;
      if (pending_cnt_o !== '0) begin errors++; $display("FAIL burst_pending_end: got %0d required 0", pending_cnt_o); end
   endtask

   task automatic test_simultaneous();
      alloc(32'h300, 32'h11111111, 4'h1, 1'b0);
      alloc(32'h304, 32'h22222222, 4'h2, 1'b0);
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd1;
      @(negedge clk);
      checks++;
      if ({sq_pop_valid_o, pending_cnt_o} !== {1'b1, 5'd1}) begin
         errors++; $display("FAIL simul_pre: got pop=%b pending=%0d required pop=1 pending=1", sq_pop_valid_o, pending_cnt_o);
      end
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      checks++;
      if (pending_cnt_o !== 5'd1) begin errors++; $display("FAIL simul_hold: got %0d required 1", pending_cnt_o); end
      wait_idle();
   endtask

   task automatic test_error();
      int p0 = pop_cnt;
      int e0 = err_pulses;
      alloc(32'h400, 32'h0000AAAA, 4'hF, 1'b0);
      alloc(32'h404, 32'h0000BBBB, 4'hC, 1'b1);
      alloc(32'h408, 32'h0000CCCC, 4'h3, 1'b0);
      commit_store_cnt_i = 2'd2;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      wait_idle();
      checks++;
      if (err_pulses - e0 != 1) begin errors++; $display("FAIL err_pulses: got %0d required 1", err_pulses - e0); end
      checks++;
      if (pop_cnt - p0 != 3) begin errors++; $display("FAIL err_pops: got %0d required 3", pop_cnt - p0); end
   endtask

   task automatic test_flush_idle();
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      checks++;
      if ({drain_busy_o, mem_req_valid_o, pending_cnt_o} !== '0) begin
         errors++; $display("FAIL flush_idle: got busy=%b valid=%b pending=%0d required 0/0/0",
                            drain_busy_o, mem_req_valid_o, pending_cnt_o);
      end
   endtask

   task automatic test_reset_in_req();
      bit seen = 1'b0;
      mem_req_ready_i = 1'b0;
      alloc(32'h500, 32'h55555555, 4'hF, 1'b0);
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req_valid_o) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rreq_no_request: got valid=0 required 1"); end
      @(posedge clk); #1;
      rst_i = 1'b1;
      sq_q.delete();
      exp_q.delete();
      infl_err.delete();
      @(posedge clk); #1;
      checks++;
      if ({mem_req_valid_o, drain_busy_o, pending_cnt_o} !== '0) begin
         errors++; $display("FAIL rreq_cleared: got valid=%b busy=%b pending=%0d required 0/0/0",
                            mem_req_valid_o, drain_busy_o, pending_cnt_o);
      end
      rst_i = 1'b0;
      mem_req_ready_i = 1'b1;
      @(posedge clk); #1;
      // Controller drains normally after the reset.
      alloc(32'h600, 32'h66666666, 4'h5, 1'b0);
      commit_store_cnt_i = 2'd1;
      @(posedge clk); #1;
      commit_store_cnt_i = 2'd0;
      wait_idle();
   endtask

   initial begin : main
      test_reset();
      test_single();
      test_backpressure();
      test_burst();
      test_simultaneous();
      test_error();
      test_flush_idle();
      test_reset_in_req();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sq_drain_ctrl
`default_nettype wire
